barrel_shift_left_pipe: RTL

- Pipelined left-direction barrel shifter; the complement of the existing combinational right shifter.
- Same 2:1-mux stage structure (shift by 2^(SHW-1) down to 1), but each stage is registered, with a valid/ready handshake on both ends.
- Supports logical-left and rotate-left.
- Sits in the datapath feeding ALU/normaliser logic that needs sustained 1-op/cycle throughput with back-pressure.

---
 rtl/barrel_shift_left_pipe_if.sv | 40 ++++
 rtl/barrel_shift_left_pipe.sv | 95 +++++++++
 2 files changed

// File: rtl/barrel_shift_left_pipe_if.sv
// Operand/result stream bundle for the pipelined left barrel shifter.
// master drives operands and result acceptance; slave is the shifter.
interface barrel_shift_left_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_lost;

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_rot,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_lost
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_rot,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_lost
  );
endinterface

// File: rtl/barrel_shift_left_pipe.sv
// Pipelined left barrel shifter, one registered 2:1 mux stage per amount bit.
// Supports logical (zero fill, lost-bit flag) and rotate; valid/ready both ends.
module barrel_shift_left_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic clk,
  input logic rst_n,
  barrel_shift_left_pipe_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   amt;
    logic             rot;
    logic             lost;
  } stg_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  stg_t           st  [SHW];
  stg_t           src [SHW];
  stg_t           nxt [SHW];
  logic [SHW-1:0] v;
  logic [SHW-1:0] rdy;

  always_comb begin
    src[0] = '{
      v:    bus.in_valid,
      d:    bus.in_data,
      amt:  bus.in_amt,
      rot:  bus.in_rot,
      lost: 1'b0
    };
    for (int k = 1; k < SHW; k++) begin
      src[k] = st[k-1];
    end
  end

  // stage k consumes amount bit SHW-1-k (largest shift first)
  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < SHW; k++) begin
      nxt[k] = src[k];
      s = 1 << (SHW - 1 - k);
      if (src[k].amt[SHW-1-k]) begin
        nxt[k].amt[SHW-1-k] = 1'b0;
        if (src[k].rot) begin
          nxt[k].d = (src[k].d << s) |
                     (src[k].d >> (WIDTH - s));
        end else begin
          nxt[k].d = src[k].d << s;
          nxt[k].lost = src[k].lost |
                        (|(src[k].d & ~(ONES >> s)));
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      v[k] = st[k].v;
    end
  end

  // a stage can load if any stage at or after it is empty, or output drains
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < SHW; j++) begin
        if (!v[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (rdy[k]) st[k] <= nxt[k];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = st[SHW-1].v;
  assign bus.out_data  = st[SHW-1].d;
  assign bus.out_lost  = st[SHW-1].lost;

endmodule
